// File: rtl/dm_responder_if.sv
// Request/response bus between the Memory-stage load/store port and dm_responder.
// The master (the core or testbench) drives requests and consumes responses.
// The slave (the responder) accepts requests and returns responses.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Word-addressed data-memory responder with configurable wait states.
// - Handles one outstanding transaction at a time: IDLE -> BUSY -> RESP.
// - Stores honour byte enables.
// - Misaligned and out-of-range accesses are rejected with resp_err.
// - Optional store trace: define DM_WRITE_LOG_EN to print one line per committed store.
module dm_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,   // asynchronous, active low
  dm_responder_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;
  logic [3:0]  be_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] pc_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  addr_err;
  logic                  access;
  logic [31:0]           cur_word;
  logic [31:0]           merged_word;

  assign word_idx = addr_reg[DEPTH_LOG2+1:2];
  // Shift rather than slice so the range check stays legal for any DEPTH_LOG2.
  assign addr_err = (addr_reg[1:0] != 2'b00) || ((addr_reg >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign access   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign cur_word = mem[word_idx];

  // Byte-lane merge of store data over the current word contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] = be_reg[gi] ? wdata_reg[8*gi +: 8] : cur_word[8*gi +: 8];
  end

  assign bus.req_ready  = (state_reg == IDLE) && reset;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

  // Transaction FSM: latch the request, count wait states, register the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      we_reg         <= 1'b0;
      be_reg         <= 4'd0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      pc_reg         <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg    <= bus.req_we;
            be_reg    <= bus.req_be;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            pc_reg    <= bus.req_pc;
            cnt_reg   <= WAIT_INIT;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= addr_err;
            resp_rdata_reg <= (!addr_err && !we_reg) ? cur_word : 32'd0;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Memory array: cleared on reset, committed stores write only enabled bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (access && we_reg && !addr_err) begin
      mem[word_idx] <= merged_word;
    end
  end

`ifdef DM_WRITE_LOG_EN
  // Trace every committed, non-empty store with the resulting full word.
  always @(posedge clk) begin
    if (reset && access && we_reg && !addr_err && (be_reg != 4'd0)) begin
      $display("%0t@%h: *%h <= %h", $time, pc_reg, {addr_reg[31:2], 2'b00}, merged_word);
    end
  end
`else
  // The PC is only consumed by the store trace.
  logic unused_pc;
  assign unused_pc = ^pc_reg;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder.
// - Main DUT uses WAIT_CYCLES=2 and is exercised with a vector table plus backpressure and reset sequences.
// - A second DUT with WAIT_CYCLES=0 covers the minimum-latency case.
module tb_dm_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_responder_if bus ();
  dm_responder_if bus0 ();

  dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request on the main DUT and wait for its response (entered and left at posedge+1).
  task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_pc    = 32'h0000_4000 + addr;
    @(posedge clk); #1;
    // Scramble the request lines to show that the latched copy is used.
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_be    = ~be;
    bus.req_addr  = 32'hFFFF_FFFC;
    bus.req_wdata = ~wdata;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1; lat++;
      if (bus.resp_valid) break;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
  endtask

  // Same as run_txn, for the zero-wait DUT.
  task automatic run_txn0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
    int n;
    n = 0;
    while (!bus0.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_be    = be;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    bus0.req_pc    = 32'h0000_8000;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1; lat++;
      if (bus0.resp_valid) break;
    end
    rdata = bus0.resp_rdata;
    err   = bus0.resp_err;
  endtask

  // Load helper with full response checking and handshake check (resp_ready held at 1).
  task automatic load_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          lat;
    run_txn(1'b0, 4'h0, addr, 32'h0, rd, er, lat);
    chk({name, "_lat"}, 32'(lat), 32'd3);
    chk({name, "_rdata"}, rd, exp);
    chk({name, "_err"}, {31'd0, er}, 32'd0);
    @(posedge clk); #1;
    $display("load  addr=%h rdata=%h err=%0b lat=%0d", addr, rd, er, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] held_rdata;
    logic        er;
    int          lat;
    int          seen_valid;

    bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_be  = 4'h0;
    bus.req_addr   = 32'h0; bus.req_wdata = 32'h0; bus.req_pc = 32'h0;
    bus.resp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_be = 4'h0;
    bus0.req_addr  = 32'h0; bus0.req_wdata = 32'h0; bus0.req_pc = 32'h0;
    bus0.resp_ready = 1'b1;

    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_1100, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h5555_5555, 32'hDEAD_11EF, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0000_0012, 32'h0,         32'h0, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 32'h0000_1000, 32'h0,         32'h0, 1'b1};
    vecs[6]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h0, 1'b0};
    vecs[8]  = '{1'b1, 4'hF, 32'h0000_0013, 32'hAAAA_AAAA, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_11EF, 1'b0};
    vecs[10] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_11EF, 1'b0};
    vecs[12] = '{1'b1, 4'h9, 32'h0000_0FFC, 32'h0A0B_0C0D, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0,         32'h0A00_000D, 1'b0};
    vecs[14] = '{1'b0, 4'h0, 32'h8000_0010, 32'h0,         32'h0, 1'b1};

    // Reset state
    @(posedge clk); #1;
    chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
    chk("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
    reset = 1'b1;
    #1;
    chk("rst_release_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      $display("txn %0d we=%0b be=%h addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
               i, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      @(posedge clk); #1;
      chk($sformatf("v%0d_hs_valid", i), {31'd0, bus.resp_valid}, 32'd0);
      chk($sformatf("v%0d_hs_ready", i), {31'd0, bus.req_ready}, 32'd1);
    end

    // Backpressure: response held while resp_ready=0, competing request ignored
    bus.resp_ready = 1'b0;
    run_txn(1'b0, 4'h0, 32'h0000_0010, 32'h0, rd, er, lat);
    held_rdata = rd;
    chk("bp_rdata", rd, 32'hDEAD_11EF);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 4'hF;
    bus.req_addr = 32'h0000_0010; bus.req_wdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), {31'd0, bus.resp_valid}, 32'd1);
      chk($sformatf("bp%0d_rdata", c), bus.resp_rdata, held_rdata);
      chk($sformatf("bp%0d_err", c), {31'd0, bus.resp_err}, 32'd0);
      chk($sformatf("bp%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp_hs_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("bp_hs_req_ready", {31'd0, bus.req_ready}, 32'd1);
    $display("backpressure released rdata=%h", held_rdata);
    load_chk("bp_after", 32'h0000_0010, 32'hDEAD_11EF);

    // Reset pulse while BUSY on a store
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 4'hF;
    bus.req_addr = 32'h0000_0020; bus.req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen_valid++;
    end
    chk("midrst_no_resp", 32'(seen_valid), 32'd0);
    chk("midrst_req_ready_after", {31'd0, bus.req_ready}, 32'd1);
    $display("reset pulse during busy store to 00000020");
    load_chk("midrst_0x20", 32'h0000_0020, 32'h0);
    load_chk("midrst_0x10", 32'h0000_0010, 32'h0);

    // Zero-wait DUT: response on the edge after acceptance
    run_txn0(1'b1, 4'hF, 32'h0000_0008, 32'h1122_3344, rd, er, lat);
    $display("w0 store addr=00000008 rdata=%h err=%0b lat=%0d", rd, er, lat);
    chk("w0_st_lat", 32'(lat), 32'd1);
    chk("w0_st_rdata", rd, 32'h0);
    chk("w0_st_err", {31'd0, er}, 32'd0);
    @(posedge clk); #1;
    chk("w0_hs_ready", {31'd0, bus0.req_ready}, 32'd1);
    run_txn0(1'b0, 4'h0, 32'h0000_0008, 32'h0, rd, er, lat);
    $display("w0 load  addr=00000008 rdata=%h err=%0b lat=%0d", rd, er, lat);
    chk("w0_ld_lat", 32'(lat), 32'd1);
    chk("w0_ld_rdata", rd, 32'h1122_3344);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Word-addressed data-memory responder serving the load/store port of the pipelined core's Memory stage, over a valid/ready request/response handshake.
- Single outstanding transaction, configurable wait states, byte-enable writes, misalignment and range error reporting.
- Used in place of the zero-latency data memory so stall logic can be exercised against a slow memory.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words, byte range 0x0000_0000 to 0x0000_0FFF).
- WAIT_CYCLES, 2, extra cycles between request acceptance and access (0 to 15).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_be  in  4  byte enables; bit i selects wdata[8i+7:8i]; ignored on loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_pc  in  32  PC of the issuing instruction; used only by the optional log.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  32  load data; 0 for stores and on error.
- resp_err  out  1  access rejected.

Behaviour:
- FSM states are IDLE, BUSY and RESP. A 4-bit wait counter is used in BUSY.
- Reset (reset=0, asynchronous):
  - Effects: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, all memory words=0.
  - While reset=0, req_ready is forced to 0.
- req_ready=1 exactly when state=IDLE and reset=1. It is a combinational decode of state.
- Acceptance:
  - Occurs on a rising edge with req_valid and req_ready both 1.
  - Latches req_we, req_be, req_addr, req_wdata and req_pc. Later changes on the req_* inputs are ignored.
  - Sets counter=WAIT_CYCLES and state=BUSY.
- BUSY:
  - If counter≠0: counter decrements each edge.
  - If counter=0: the access is performed on that edge and state becomes RESP.
  - The access edge is therefore acceptance edge + WAIT_CYCLES + 1.
- Error check (evaluated on the latched address):
  - Misaligned: addr[1:0]≠0.
  - Out of range: addr[31:DEPTH_LOG2+2]≠0.
  - Either condition sets resp_err=1 and resp_rdata=0, and memory is not modified.
- Load: resp_rdata = mem[addr[DEPTH_LOG2+1:2]], registered on the access edge; resp_err=0.
- Store:
  - Only enabled bytes are written on the access edge; other bytes are preserved.
  - resp_rdata=0, resp_err=0.
  - be=4'b0000 is a legal no-op store with resp_err=0.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - The handshake is an edge with resp_valid and resp_ready both 1. At that edge, state becomes IDLE and resp_valid becomes 0.
  - req_ready returns to 1 in the following cycle. No request is accepted in the handshake cycle itself.
- Minimum turnaround per transaction is WAIT_CYCLES + 3 cycles with resp_ready held at 1.
- Reset asserted mid-transaction:
  - The transaction is aborted with no write committed and no response issued.
  - Memory is cleared. If the access edge and reset coincide, reset wins.
- Memory reads are never combinational; resp_rdata changes only on the access edge or on reset.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- With the macro defined:
  - Every committed store with be≠0 prints one simulation line at the access edge: "<time>@<pc hex>: *<word-aligned addr hex> <= <resulting full word hex>".
  - req_pc is the latched PC.
  - Errored and be=0 stores print nothing.
- Without the macro: no display statements are compiled; req_pc is latched but unused. Functional behaviour is identical.

Test Plan:
- Reset, then store addr=0x0000_0010, wdata=0xDEADBEEF, be=4'hF, WAIT_CYCLES=2, resp_ready=1 -> resp_valid rises 3 edges after acceptance with resp_err=0 and resp_rdata=0; a following load from 0x10 returns 0xDEADBEEF.
- Byte merge: word 0x10=0xDEADBEEF; store wdata=0x0000_1100, be=4'b0010 -> a load from 0x10 returns 0xDEAD11EF.
- Misaligned load addr=0x0000_0012 and out-of-range load addr=0x0000_1000 -> each gives resp_err=1, resp_rdata=0, memory unchanged (load 0x10 still returns 0xDEAD11EF).
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stay constant and req_ready stays 0; release -> req_ready=1 one cycle after the handshake edge.
- Reset pulsed low for 1 cycle while in BUSY on store 0x20 <= 0x12345678 -> no response issued, req_ready=1 after release, load 0x20 returns 0.
- WAIT_CYCLES=0 build -> resp_valid rises on the edge after acceptance. With DM_WRITE_LOG_EN, each committed store prints exactly one line, and the errored store prints none.
